// File: rtl/seg_digit_counter.sv
// Single BCD digit counter with programmable tick prescaler, direction and parallel load,
// plus a 7-segment encoder whose output only changes at the start of a vertical sync pulse.
module seg_digit_counter #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       v_sync_i,
  output logic [3:0] digit_o,
  output logic       carry_o,
  output logic [6:0] seg_o
);

  localparam logic [PRE_W-1:0] PreMax = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]       DigMax = 4'd9;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       digit_q, digit_d;
  logic             carry_q, carry_d;
  logic             vs_q;
  logic [6:0]       seg_q, seg_d;

  logic tick;
  logic vs_fall;
  logic wrap;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign tick    = en_i && (pre_q == PreMax);
  assign vs_fall = vs_q && !v_sync_i;
  assign wrap    = up_i ? (digit_q == DigMax) : (digit_q == 4'd0);

  // Prescaler: load restarts the tick phase; a disabled counter keeps its phase.
  always_comb begin
    pre_d = pre_q;
    if (load_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = (pre_q == PreMax) ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Digit: load beats tick; an out-of-range load value is ignored but still eats the tick.
  always_comb begin
    digit_d = digit_q;
    carry_d = 1'b0;
    if (load_i) begin
      if (load_val_i <= DigMax) begin
        digit_d = load_val_i;
      end
    end else if (tick) begin
      carry_d = wrap;
      if (up_i) begin
        digit_d = wrap ? 4'd0 : digit_q + 4'd1;
      end else begin
        digit_d = wrap ? DigMax : digit_q - 4'd1;
      end
    end
  end

  // Latch uses the pre-update digit so a same-edge tick shows up one frame later.
  always_comb begin
    seg_d = seg_q;
    if (vs_fall) begin
      seg_d = encode(digit_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q   <= '0;
      digit_q <= 4'd0;
      carry_q <= 1'b0;
      vs_q    <= 1'b1;
      seg_q   <= 7'h3F;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
      carry_q <= carry_d;
      vs_q    <= v_sync_i;
      seg_q   <= seg_d;
    end
  end

  assign digit_o = digit_q;
  assign carry_o = carry_q;
  assign seg_o   = seg_q;

  a_digit_bcd: assert property (@(posedge clk_i) disable iff (!rst_ni) digit_q <= DigMax);
  a_carry_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni) carry_q |=> !carry_q);
  a_pre_range: assert property (@(posedge clk_i) disable iff (!rst_ni) pre_q <= PreMax);

endmodule

// File: tb/tb_seg_digit_counter.sv
// Randomised bench for seg_digit_counter: driver feeds a behavioural model and a queue of
// expected outputs; a monitor pops one entry per clock and compares.
module tb_seg_digit_counter;

  localparam int TickDiv = 4;

  logic       clk_i;
  logic       rst_ni;
  logic       en_i;
  logic       up_i;
  logic       load_i;
  logic [3:0] load_val_i;
  logic       v_sync_i;
  logic [3:0] digit_o;
  logic       carry_o;
  logic [6:0] seg_o;

  seg_digit_counter #(
    .TICK_DIV(TickDiv),
    .PRE_W   (3)
  ) u_dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .up_i      (up_i),
    .load_i    (load_i),
    .load_val_i(load_val_i),
    .v_sync_i  (v_sync_i),
    .digit_o   (digit_o),
    .carry_o   (carry_o),
    .seg_o     (seg_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] d;
    logic       c;
    logic [6:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference state: enabled cycles since the tick phase started, digit as an integer.
  int         m_cnt;
  int         m_digit;
  bit         m_carry;
  logic [6:0] m_seg;
  bit         m_vs;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_digit = 0;
    m_carry = 0;
    m_seg   = 7'h3F;
    m_vs    = 1;
  endtask

  // Called at a negedge: drive one cycle of stimulus, predict the next edge, wait a cycle.
  task automatic step(input bit e, input bit u, input bit ld, input logic [3:0] lv);
    bit   vs;
    exp_t x;
    vs         = (cyc % 20) >= 2;
    cyc++;
    en_i       = e;
    up_i       = u;
    load_i     = ld;
    load_val_i = lv;
    v_sync_i   = vs;
    if (m_vs && !vs) m_seg = glyph[m_digit];
    m_vs    = vs;
    m_carry = 0;
    if (ld) begin
      m_cnt = 0;
      if (lv < 10) m_digit = int'(lv);
    end else if (e) begin
      m_cnt++;
      if (m_cnt == TickDiv) begin
        m_cnt = 0;
        if (u) begin
          m_carry = (m_digit == 9);
          m_digit = (m_digit + 1) % 10;
        end else begin
          m_carry = (m_digit == 0);
          m_digit = (m_digit + 9) % 10;
        end
      end
    end
    x.d = 4'(m_digit);
    x.c = m_carry;
    x.s = m_seg;
    exp_q.push_back(x);
    @(negedge clk_i);
  endtask

  task automatic run(input int n, input bit u);
    for (int i = 0; i < n; i++) step(1'b1, u, 1'b0, 4'd0);
  endtask

  // Mid-cycle asynchronous reset, checked before any clock edge can act on it.
  task automatic async_reset();
    exp_t x;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_digit", int'(digit_o), 0);
    chk("rst_carry", int'(carry_o), 0);
    chk("rst_seg", int'(seg_o), 'h3F);
    model_reset();
    x.d = 4'd0;
    x.c = 1'b0;
    x.s = 7'h3F;
    exp_q.push_back(x);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  always begin
    exp_t e;
    @(posedge clk_i);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("digit", int'(digit_o), int'(e.d));
      chk("carry", int'(carry_o), int'(e.c));
      chk("seg", int'(seg_o), int'(e.s));
    end
  end

  initial begin
    rst_ni     = 1'b0;
    en_i       = 1'b0;
    up_i       = 1'b1;
    load_i     = 1'b0;
    load_val_i = 4'd0;
    v_sync_i   = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("init_digit", int'(digit_o), 0);
    chk("init_seg", int'(seg_o), 'h3F);
    rst_ni = 1'b1;

    run(40, 1'b1);

    step(1'b1, 1'b1, 1'b1, 4'd0);
    run(12, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, (i / 3) % 2 == 0, 1'b0, 4'd0);

    // Load lands exactly on a tick cycle, then an illegal load value.
    step(1'b1, 1'b1, 1'b1, 4'd2);
    run(3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'd7);
    run(9, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'd12);
    run(9, 1'b1);

    step(1'b1, 1'b1, 1'b1, 4'd3);
    run(24, 1'b1);

    step(1'b1, 1'b1, 1'b1, 4'd0);
    run(2, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
    run(6, 1'b1);

    step(1'b1, 1'b1, 1'b1, 4'd5);
    run(2, 1'b1);
    async_reset();
    run(10, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)));
      if (i == 700) async_reset();
    end

    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_digit_counter.md
# seg_digit_counter

Single-digit decimal counter and 7-segment encoder that drives the `seg[6:0]` input of the VGA segment display stage. It advances a BCD digit at a programmable tick rate, supports direction and parallel load, and encodes the digit to segment form. The `seg` output is updated only at the start of a vertical sync pulse, so the displayed glyph never changes mid-frame.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per count tick while enabled; legal range 2..2^26.
- `PRE_W`, default 26: prescaler width; must satisfy 2^PRE_W ≥ TICK_DIV.

Ports:
- `clk`, input, 1: system clock; all logic uses its rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `en`, input, 1: count enable; when 0, the prescaler and the digit hold.
- `up`, input, 1: direction; 1 = increment, 0 = decrement.
- `load`, input, 1: synchronous parallel load strobe.
- `load_val`, input, 4: value loaded when `load`=1; values 10..15 are illegal.
- `v_sync`, input, 1: active-low vertical sync from the display stage, same clock domain.
- `digit`, output, 4: current BCD digit, 0..9.
- `carry`, output, 1: one-cycle pulse on wrap.
- `seg`, output, 7: frame-latched segment pattern; bit0 = A … bit6 = G; 1 = lit.

## Operation
- **Prescaler `pre` (PRE_W bits):**
  - When `en`=1 and `load`=0: `pre` counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` is asserted (combinationally) when `en`=1 and `pre`==TICK_DIV-1.
  - When `en`=0: `pre` holds its value; it is not cleared.
  - When `load`=1: `pre` is cleared to 0, regardless of `en`.
- **Digit register, priority order:**
  1. `load`=1 with `load_val`≤9: `digit` ← `load_val`.
  2. `load`=1 with `load_val`>9: `digit` unchanged; the prescaler is still cleared.
  3. `tick` with `up`=1: `digit` ← `digit`+1, except 9 → 0.
  4. `tick` with `up`=0: `digit` ← `digit`-1, except 0 → 9.
- **`carry`:**
  - Registered. It is 1 for exactly the cycle after a tick that wraps 9→0 (up) or 0→9 (down); otherwise 0.
  - A load never produces `carry`, even when a tick occurs in the same cycle.
- **Encoder (combinational on `digit`), values in hex:** 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F. Digit values 10..15 are unreachable; if forced, they encode to 00.
- **Frame latch:**
  - `vs_q` is a register of `v_sync`.
  - `vs_fall` = `vs_q` & ~`v_sync`.
  - On `vs_fall`, `seg` ← encode(`digit`), using the registered `digit` value before any same-cycle update.
  - At all other times, `seg` holds.
  - `v_sync` held low, or a glitch-free held-high level, produces no further updates.
- **Reset (`rst`=0), asynchronous:**
  - `pre`=0, `digit`=0, `carry`=0, `vs_q`=1, `seg`=7'h3F.
  - Reset asserted mid-count discards any pending tick; the first tick after release occurs TICK_DIV enabled cycles later.

## Timing
- `digit` changes on the clock edge where `tick` or `load` is sampled, so it is visible 1 cycle after the strobe.
- `carry` rises on that same edge and lasts 1 cycle.
- `seg` updates on the edge where `vs_fall` is true: 1 cycle after the first low sample of `v_sync`, counted from the edge at which `v_sync` changes.
- Maximum latency from a digit change to `seg` is one display frame plus 1 cycle.
- Tick period with `en` held high: exactly TICK_DIV cycles. The first tick after reset or load occurs on the TICK_DIV-th enabled cycle.
- `en` pauses the tick phase; the enabled-cycle count continues after resume.
- `up` is sampled only on tick cycles; changing it between ticks has no other effect.
- The block has no handshake. The display stage consumes `seg` as a static level.

## Test plan
Unless a scenario says otherwise, the bench uses TICK_DIV=4, `en`=1, `up`=1, and `v_sync` pulsed low for 2 cycles every 20 cycles.
- **Reset:** assert `rst`=0 mid-run → `digit`=0, `carry`=0, `seg`=3F immediately, without a clock edge. Release → the first increment occurs 4 cycles later.
- **Up wrap:** run through 40 cycles → `digit` sequence 0,1,…,9,0. `carry` is a single-cycle pulse coincident with the 9→0 step, and is 0 elsewhere.
- **Down wrap:** `up`=0 starting from 0 → next digit is 9 with a `carry` pulse, then 8. `up` toggled between ticks → each step follows `up` as sampled on its tick cycle.
- **Load priority:**
  - `load`=1 with `load_val`=7 on a tick cycle → `digit`=7, no `carry`, next tick 4 cycles later.
  - `load_val`=12 → `digit` unchanged, prescaler cleared.
- **Frame latch:**
  - `digit` changes from 3 to 4 mid-frame → `seg` stays 4F until 1 cycle after the `v_sync` falling edge, then becomes 66.
  - Tick and `vs_fall` in the same cycle → `seg` takes the old digit's pattern.
- **Enable hold:** drop `en` after 2 enabled cycles for 10 cycles, then raise it → `digit` holds during the pause, and the tick arrives after 2 further enabled cycles.
